gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv | 190 +++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter
// Purpose  : Reference-clocked ring-oscillator frequency meter. Counts rising
//            edges of RO_IN over a programmable window of CLK cycles, so
//            f_ro = COUNT * f_clk / WINDOW.
// Ports    : CLK    - reference clock, all state on rising edge
//            RN     - asynchronous active-low reset
//            RO_IN  - ring-oscillator output, asynchronous to CLK
//            START  - single-cycle measurement request
//            ABORT  - cancel a measurement in progress (wins over START)
//            WINDOW - measurement length in CLK cycles, sampled with START
//            BUSY   - measurement in progress (ARM, CNT, FIN)
//            DONE   - one-cycle pulse while COUNT/OVF present a new result
//            COUNT  - edge count of the last completed measurement
//            OVF    - edge counter saturated during the last measurement
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             RO_IN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_arm  = 2'd1;
  localparam logic [1:0] c_st_cnt  = 2'd2;
  localparam logic [1:0] c_st_fin  = 2'd3;

  // ARM lasts SYNC_STAGES+1 cycles: the arm timer runs 0..SYNC_STAGES.
  localparam logic [2:0] c_arm_last = 3'(SYNC_STAGES);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_edge;
  logic [2:0]             r_arm;
  logic [WIN_W-1:0]       r_win;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf_pend;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_ovf_nxt;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;

  // --------------------------------------------------------------------------
  // RO_IN synchroniser and rising-edge detector; runs in every state so the
  // chain is always settled by the time ARM has flushed it.
  // --------------------------------------------------------------------------
  generate
    if (SYNC_STAGES > 1) begin : g_sync_multi
      always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
          r_sync <= '0;
          r_prev <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], RO_IN};
          r_prev <= r_sync[SYNC_STAGES-1];
        end
      end
    end else begin : g_sync_single
      always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
          r_sync <= '0;
          r_prev <= 1'b0;
        end else begin
          r_sync <= RO_IN;
          r_prev <= r_sync[SYNC_STAGES-1];
        end
      end
    end
  endgenerate

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // --------------------------------------------------------------------------
  // Saturating edge counter next-value. Overflow is flagged by an edge that
  // arrives while the counter already holds all-ones.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf_pend;
    if ((r_state == c_st_cnt) && w_edge) begin
      if (&r_cnt) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (START && !ABORT) begin
          w_state_nxt = c_st_arm;
        end
      end
      c_st_arm: begin
        if (ABORT) begin
          w_state_nxt = c_st_idle;
        end else if (r_arm == c_arm_last) begin
          // A zero-length window skips counting entirely.
          w_state_nxt = (r_win == '0) ? c_st_fin : c_st_cnt;
        end
      end
      c_st_cnt: begin
        if (ABORT) begin
          w_state_nxt = c_st_idle;
        end else if (r_win == WIN_W'(1)) begin
          w_state_nxt = c_st_fin;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, timers and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state    <= c_st_idle;
      r_arm      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        c_st_idle: begin
          if (START && !ABORT) begin
            r_win      <= WINDOW;
            r_arm      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
          end
        end
        c_st_arm: begin
          r_arm <= r_arm + 3'd1;
        end
        c_st_cnt: begin
          // r_win doubles as the remaining-cycles counter during CNT.
          r_win      <= r_win - WIN_W'(1);
          r_cnt      <= w_cnt_nxt;
          r_ovf_pend <= w_ovf_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers are loaded on entry to FIN so they are valid for the
  // whole DONE cycle, including an edge seen on the final CNT cycle.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if ((w_state_nxt == c_st_fin) && (r_state != c_st_fin)) begin
      r_count <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign BUSY  = (r_state != c_st_idle);
  assign DONE  = (r_state == c_st_fin);
  assign COUNT = r_count;
  assign OVF   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter
// Purpose  : Scoreboard bench for the ring-oscillator frequency meter. Two
//            instances share stimulus: a 16-bit counter and a 4-bit counter
//            that saturates on the faster runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter;

  localparam int SYNC = 2;

  typedef struct {
    logic [15:0] count;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rn;
  logic        ro_in;
  logic        start;
  logic        abort;
  logic [15:0] window;
  logic        busy16, done16, ovf16;
  logic [15:0] count16;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;

  int   cyc;
  int   n_vec;
  int   n_err;
  int   t_start;
  int   ro_half;
  logic ro_hold;
  exp_t q16[$];
  exp_t q4[$];

  gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(
    .CNT_W(16), .WIN_W(16), .SYNC_STAGES(SYNC)
  ) dut16 (
    .CLK(clk), .RN(rn), .RO_IN(ro_in), .START(start), .ABORT(abort),
    .WINDOW(window), .BUSY(busy16), .DONE(done16), .COUNT(count16), .OVF(ovf16)
  );

  gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(
    .CNT_W(4), .WIN_W(16), .SYNC_STAGES(SYNC)
  ) dut4 (
    .CLK(clk), .RN(rn), .RO_IN(ro_in), .START(start), .ABORT(abort),
    .WINDOW(window), .BUSY(busy4), .DONE(done4), .COUNT(count4), .OVF(ovf4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Clock-synchronous oscillator model: toggles every ro_half cycles, or
  // holds ro_hold when ro_half is zero.
  initial begin
    int ph;
    ph    = 0;
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ro_half == 0) begin
        ro_in = ro_hold;
        ph    = 0;
      end else begin
        ph = ph + 1;
        if (ph >= ro_half) begin
          ph    = 0;
          ro_in = ~ro_in;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DONE pulse is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done16) begin
        if (q16.size() == 0) begin
          check("done16_unexpected", 32'd1, 32'd0);
        end else begin
          e = q16.pop_front();
          check("count16", 32'(count16), 32'(e.count));
          check("ovf16", 32'(ovf16), 32'(e.ovf));
          check("done16_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done4) begin
        if (q4.size() == 0) begin
          check("done4_unexpected", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          check("count4", 32'(count4), 32'(e.count));
          check("ovf4", 32'(ovf4), 32'(e.ovf));
          check("done4_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Issue START and push the expected result for both instances.
  task automatic issue(input int w, input int c16, input int o16, input int c4, input int o4);
    exp_t e;
    @(negedge clk);
    window  = 16'(w);
    start   = 1'b1;
    t_start = cyc + 1;
    e.cyc   = t_start + SYNC + 1 + w;
    e.count = 16'(c16);
    e.ovf   = o16[0];
    q16.push_back(e);
    e.count = 16'(c4);
    e.ovf   = o4[0];
    q4.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for BUSY to drop (bounded) and check the busy length.
  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (busy16 && n < w + 100) begin
      @(negedge clk);
      n = n + 1;
    end
    check("busy_len", 32'(cyc - t_start), 32'(w + SYNC + 2));
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int w, input int c16, input int o16, input int c4, input int o4);
    issue(w, c16, o16, c4, o4);
    wait_idle(w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    n_vec   = 0;
    n_err   = 0;
    t_start = 0;
    ro_half = 0;
    ro_hold = 1'b0;
    rn      = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    window  = 16'd0;

    // Reset state
    #2 rn = 1'b0;
    #1;
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_count", 32'(count16), 32'd0);
    check("rst_ovf", 32'(ovf16), 32'd0);
    repeat (3) @(negedge clk);
    rn = 1'b1;

    // Idle with oscillator running: outputs stay quiet
    ro_half = 2;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy16 || done16 || ovf16 || count16 != 0 || busy4 || done4 || ovf4 || count4 != 0)
        bad = bad + 1;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Period 4, window 100: 25 edges; 4-bit instance saturates
    run(100, 25, 0, 15, 1);

    // RO held high: no edges
    ro_half = 0;
    ro_hold = 1'b1;
    repeat (10) @(negedge clk);
    run(64, 0, 0, 0, 0);

    // Period 8, window 64: 8 edges
    ro_half = 4;
    repeat (10) @(negedge clk);
    run(64, 8, 0, 8, 0);

    // Period 4, window 40: 10 edges, 4-bit overflow cleared
    ro_half = 2;
    run(40, 10, 0, 10, 0);

    // Establish 25 / 15+OVF, then abort mid-count
    run(100, 25, 0, 15, 1);
    @(negedge clk);
    window = 16'd100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy16), 32'd0);
    repeat (110) @(negedge clk);
    check("abort_count16", 32'(count16), 32'd25);
    check("abort_count4", 32'(count4), 32'd15);
    check("abort_ovf4", 32'(ovf4), 32'd1);

    // START and ABORT together in IDLE: ABORT wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy16), 32'd0);

    // Zero-length window
    run(0, 0, 0, 0, 0);

    // START while busy is ignored, WINDOW not re-sampled
    issue(20, 5, 0, 5, 0);
    repeat (5) @(negedge clk);
    window = 16'd50;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(20);

    // Reset mid-count
    run(100, 25, 0, 15, 1);
    @(negedge clk);
    window = 16'd100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy16), 32'd0);
    check("midrst_count16", 32'(count16), 32'd0);
    check("midrst_ovf4", 32'(ovf4), 32'd0);
    check("midrst_count4", 32'(count4), 32'd0);
    @(negedge clk);
    rn = 1'b1;
    repeat (5) @(negedge clk);

    // Fresh measurement after reset
    run(40, 10, 0, 10, 0);

    repeat (10) @(negedge clk);
    check("q16_empty", 32'(q16.size()), 32'd0);
    check("q4_empty", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
